// File: rtl/sa_row_feeder.sv
// Systolic-array row feeder: accepts column-vector beats, skews lane i by
// i+1 cycles onto the PE left inputs, then flushes the array before
// signalling job completion.
module sa_row_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int N         = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_s_valid,
  output logic                   o_s_ready,
  input  logic [N*BIT_WIDTH-1:0] i_s_data,
  input  logic                   i_s_last,
  output logic [N*BIT_WIDTH-1:0] o_left_out,
  output logic                   o_en,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CNT_WIDTH-1:0]   o_beat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Flush runs 2N-1 cycles: the counter is loaded with 2N-2 and DONE is
  // entered from the cycle where it reads zero.
  localparam int FLUSH_W = $clog2(2 * N);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(2 * N - 2);

  state_t                   r_state;
  logic [FLUSH_W-1:0]       r_flush_cnt;
  logic [CNT_WIDTH-1:0]     r_beat_cnt;
  logic                     w_accept;
  logic [N*BIT_WIDTH-1:0]   w_chain_in;

  assign o_s_ready  = (r_state == ST_IDLE) || (r_state == ST_FEED);
  assign o_en       = (r_state == ST_FEED) || (r_state == ST_FLUSH);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_beat_cnt = r_beat_cnt;

  assign w_accept   = i_s_valid && o_s_ready;
  // Cycles without an accepted beat inject zero bubbles instead of stalling.
  assign w_chain_in = w_accept ? i_s_data : '0;

  // Job sequencing, flush timing and saturating beat count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_beat_cnt <= CNT_WIDTH'(1);
            if (i_s_last) begin
              r_state     <= ST_FLUSH;
              r_flush_cnt <= FLUSH_LOAD;
            end else begin
              r_state <= ST_FEED;
            end
          end
        end
        ST_FEED: begin
          if (w_accept) begin
            if (r_beat_cnt != '1) begin
              r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            end
            if (i_s_last) begin
              r_state     <= ST_FLUSH;
              r_flush_cnt <= FLUSH_LOAD;
            end
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_flush_cnt <= r_flush_cnt - FLUSH_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // One shift chain per lane, depth gi+1, shifting every cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [BIT_WIDTH-1:0] r_stage [0:gi];

      // Advance the lane's skew pipeline; reset discards in-flight data.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int k = 0; k <= gi; k++) begin
            r_stage[k] <= '0;
          end
        end else begin
          r_stage[0] <= w_chain_in[gi*BIT_WIDTH +: BIT_WIDTH];
          for (int k = 1; k <= gi; k++) begin
            r_stage[k] <= r_stage[k-1];
          end
        end
      end

      assign o_left_out[gi*BIT_WIDTH +: BIT_WIDTH] = r_stage[gi];
    end
  endgenerate

endmodule

// File: tb/tb_sa_row_feeder.sv
// Directed bench for sa_row_feeder (N=4, BIT_WIDTH=8): a CNT_WIDTH=16 and a
// CNT_WIDTH=2 instance share stimulus; every cycle's outputs are compared
// against hand-computed values.
module tb_sa_row_feeder;

  localparam int IDLE  = 0;
  localparam int FEED  = 1;
  localparam int FLUSH = 2;
  localparam int DONE  = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid;
  logic        s_last;
  logic [31:0] s_data;

  logic        ready_a, en_a, busy_a, done_a;
  logic [31:0] left_a;
  logic [15:0] cnt_a;
  logic        ready_b, en_b, busy_b, done_b;
  logic [31:0] left_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #5 clk = ~clk;

  sa_row_feeder #(.BIT_WIDTH(8), .N(4), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .i_s_valid  (s_valid),
    .o_s_ready  (ready_a),
    .i_s_data   (s_data),
    .i_s_last   (s_last),
    .o_left_out (left_a),
    .o_en       (en_a),
    .o_busy     (busy_a),
    .o_done     (done_a),
    .o_beat_cnt (cnt_a)
  );

  sa_row_feeder #(.BIT_WIDTH(8), .N(4), .CNT_WIDTH(2)) dut_sat (
    .clk        (clk),
    .resetn     (resetn),
    .i_s_valid  (s_valid),
    .o_s_ready  (ready_b),
    .i_s_data   (s_data),
    .i_s_last   (s_last),
    .o_left_out (left_b),
    .o_en       (en_b),
    .o_busy     (busy_b),
    .o_done     (done_b),
    .o_beat_cnt (cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check that cycle's outputs, then advance.
  task automatic cyc(input logic v, input logic l, input logic [31:0] d,
                     input int st, input logic [31:0] exp_left, input int exp_cnt);
    s_valid = v;
    s_last  = l;
    s_data  = d;
    #1;
    chk("s_ready",      32'(ready_a), 32'(st == IDLE || st == FEED));
    chk("en",           32'(en_a),    32'(st == FEED || st == FLUSH));
    chk("busy",         32'(busy_a),  32'(st != IDLE));
    chk("done",         32'(done_a),  32'(st == DONE));
    chk("left_out",     left_a,       exp_left);
    chk("beat_cnt",     32'(cnt_a),   32'(exp_cnt));
    chk("left_out_sat", left_b,       exp_left);
    chk("beat_cnt_sat", 32'(cnt_b),   (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
    $display("cyc %0d rst_n=%0b v=%0b l=%0b d=%08h | rdy=%0b en=%0b busy=%0b done=%0b left=%08h cnt=%0d sat=%0d",
             cycle, resetn, v, l, d, ready_a, en_a, busy_a, done_a, left_a, cnt_a, cnt_b);
    @(posedge clk);
    #1;
    cycle++;
  endtask

  initial begin
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, including garbage valid data that must not be captured.
    cyc(1'b1, 1'b0, 32'hAAAA5555, IDLE, 32'h0, 0);
    resetn = 1'b1;

    // Single beat with last: lanes 01..04 at cycles 1..4, done at 8.
    cyc(1'b1, 1'b1, 32'h04030201, IDLE,  32'h00000000, 0);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h00000001, 1);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h00000200, 1);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h00030000, 1);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h04000000, 1);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, FLUSH, 32'h0, 1);
    cyc(1'b0, 1'b0, 32'h0,        DONE,  32'h0, 1);
    cyc(1'b0, 1'b0, 32'h0,        IDLE,  32'h0, 1);

    // Four back-to-back beats, last at cycle 3, done at 11.
    cyc(1'b1, 1'b0, 32'h41312111, IDLE,  32'h00000000, 1);
    cyc(1'b1, 1'b0, 32'h42322212, FEED,  32'h00000011, 1);
    cyc(1'b1, 1'b0, 32'h43332313, FEED,  32'h00002112, 2);
    cyc(1'b1, 1'b1, 32'h44342414, FEED,  32'h00312213, 3);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h41322314, 4);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h42332400, 4);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h43340000, 4);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h44000000, 4);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, FLUSH, 32'h0, 4);
    cyc(1'b0, 1'b0, 32'h0,        DONE,  32'h0, 4);
    cyc(1'b0, 1'b0, 32'h0,        IDLE,  32'h0, 4);

    // Two-cycle valid gap mid-job: bubbles in every lane, en stays high.
    cyc(1'b1, 1'b0, 32'h41312111, IDLE,  32'h00000000, 4);
    cyc(1'b1, 1'b0, 32'h42322212, FEED,  32'h00000011, 1);
    cyc(1'b0, 1'b1, 32'hDEADBEEF, FEED,  32'h00002112, 2);
    cyc(1'b0, 1'b0, 32'hDEADBEEF, FEED,  32'h00312200, 2);
    cyc(1'b1, 1'b1, 32'h43332313, FEED,  32'h41320000, 2);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h42000013, 3);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h00002300, 3);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h00330000, 3);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h43000000, 3);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, FLUSH, 32'h0, 3);
    cyc(1'b0, 1'b0, 32'h0,        DONE,  32'h0, 3);
    cyc(1'b0, 1'b0, 32'h0,        IDLE,  32'h0, 3);

    // Valid held high through FLUSH/DONE: nothing accepted until IDLE.
    cyc(1'b1, 1'b1, 32'h41312111, IDLE,  32'h00000000, 3);
    cyc(1'b1, 1'b0, 32'hFFFFFFFF, FLUSH, 32'h00000011, 1);
    cyc(1'b1, 1'b0, 32'hFFFFFFFF, FLUSH, 32'h00002100, 1);
    cyc(1'b1, 1'b1, 32'hFFFFFFFF, FLUSH, 32'h00310000, 1);
    cyc(1'b1, 1'b0, 32'hFFFFFFFF, FLUSH, 32'h41000000, 1);
    repeat (3) cyc(1'b1, 1'b0, 32'hFFFFFFFF, FLUSH, 32'h0, 1);
    cyc(1'b1, 1'b1, 32'hFFFFFFFF, DONE,  32'h0, 1);
    cyc(1'b1, 1'b1, 32'h42322212, IDLE,  32'h0, 1);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h00000012, 1);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h00002200, 1);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h00320000, 1);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h42000000, 1);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, FLUSH, 32'h0, 1);
    cyc(1'b0, 1'b0, 32'h0,        DONE,  32'h0, 1);
    cyc(1'b0, 1'b0, 32'h0,        IDLE,  32'h0, 1);

    // Reset at cycle 2 of a 4-beat job: abort, no done pulse.
    cyc(1'b1, 1'b0, 32'h41312111, IDLE,  32'h00000000, 1);
    cyc(1'b1, 1'b0, 32'h42322212, FEED,  32'h00000011, 1);
    resetn = 1'b0;
    cyc(1'b1, 1'b0, 32'h43332313, FEED,  32'h00002112, 2);
    resetn = 1'b1;
    repeat (12) cyc(1'b0, 1'b0, 32'h0, IDLE, 32'h0, 0);

    // Five-beat job: full counter reaches 5, 2-bit counter saturates at 3.
    cyc(1'b1, 1'b0, 32'h41312111, IDLE,  32'h00000000, 0);
    cyc(1'b1, 1'b0, 32'h42322212, FEED,  32'h00000011, 1);
    cyc(1'b1, 1'b0, 32'h43332313, FEED,  32'h00002112, 2);
    cyc(1'b1, 1'b0, 32'h44342414, FEED,  32'h00312213, 3);
    cyc(1'b1, 1'b1, 32'h45352515, FEED,  32'h41322314, 4);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h42332415, 5);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h43342500, 5);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h44350000, 5);
    cyc(1'b0, 1'b0, 32'h0,        FLUSH, 32'h45000000, 5);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, FLUSH, 32'h0, 5);
    cyc(1'b0, 1'b0, 32'h0,        DONE,  32'h0, 5);
    cyc(1'b0, 1'b0, 32'h0,        IDLE,  32'h0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
